// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: MEM-stage data-cache request controller with pipeline stall/writeback control.
// Define LLSC_EN to add load-linked/store-conditional link tracking.
module mem_req_ctrl (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        req_valid,
   input  logic        req_read,
   input  logic        req_write,
   input  logic        req_ll,
   input  logic        req_sc,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        dmemREN,
   output logic        dmemWEN,
   output logic [31:0] dmemaddr,
   output logic [31:0] dmemstore,
   input  logic        dhit,
   input  logic [31:0] dmemload,
   input  logic        snoop_inv,
   input  logic [31:0] snoop_addr,
   output logic [31:0] mem_data,
   output logic        wb_enable,
   output logic        stall_o
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t      state_q;
   logic        ren_q, wen_q;
   logic [31:0] addr_q, wdata_q, mem_data_q;
   logic        mem_op, is_wr, sc_fail;
   assign is_wr  = req_valid && req_write;
   assign mem_op = req_valid && (req_read || req_write);
`ifdef LLSC_EN
   logic        link_valid_q, ll_q, sc_q;
   logic [31:0] link_addr_q;
   logic        snoop_hit, sc_ok;
   logic        unused_low_bits;
   assign snoop_hit = snoop_inv && snoop_addr[31:2] == link_addr_q[31:2];
   // a snoop arriving while the SC is evaluated already breaks the link
   assign sc_ok   = link_valid_q && !snoop_hit && req_addr[31:2] == link_addr_q[31:2];
   assign sc_fail = is_wr && req_sc && !sc_ok;
   assign unused_low_bits = ^{snoop_addr[1:0], link_addr_q[1:0]};
`else
   logic        unused_llsc;
   assign sc_fail = 1'b0;
   assign unused_llsc = ^{req_ll, req_sc, snoop_inv, snoop_addr};
`endif
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= IDLE;
         ren_q      <= 1'b0;
         wen_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mem_data_q <= '0;
`ifdef LLSC_EN
         link_valid_q <= 1'b0;
         link_addr_q  <= '0;
         ll_q         <= 1'b0;
         sc_q         <= 1'b0;
`endif
      end else begin
`ifdef LLSC_EN
         if (snoop_hit) link_valid_q <= 1'b0;
`endif
         case (state_q)
            IDLE: if (mem_op) begin
               addr_q  <= req_addr;
               wdata_q <= req_wdata;
               ren_q   <= !is_wr && !sc_fail;
               wen_q   <= is_wr && !sc_fail;
               state_q <= sc_fail ? DONE : ACCESS;
               if (sc_fail) mem_data_q <= '0;
`ifdef LLSC_EN
               ll_q <= !is_wr && req_ll;
               sc_q <= is_wr && req_sc;
`endif
            end
            ACCESS: if (dhit) begin
               ren_q   <= 1'b0;
               wen_q   <= 1'b0;
               state_q <= DONE;
               if (ren_q) mem_data_q <= dmemload;
`ifdef LLSC_EN
               if (wen_q && addr_q[31:2] == link_addr_q[31:2]) link_valid_q <= 1'b0;
               if (sc_q) mem_data_q <= 32'd1;
               if (ll_q) begin
                  link_valid_q <= 1'b1;
                  link_addr_q  <= addr_q;
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign dmemREN   = ren_q;
   assign dmemWEN   = wen_q;
   assign dmemaddr  = addr_q;
   assign dmemstore = wdata_q;
   assign mem_data  = mem_data_q;
   // IDLE decides stall/writeback from the live request so a new op stalls in its first cycle
   assign stall_o   = nRST && (state_q == ACCESS || (state_q == IDLE && mem_op));
   assign wb_enable = nRST && (state_q == DONE || (state_q == IDLE && !mem_op));
endmodule
